arb_mux_4_1: RTL and testbench

Four-requester round-robin arbiter that drives the select of a 4:1, 4-bit data multiplexer and registers the winning word into a single-entry output stage. It sits directly upstream of the consumer of the mux output: it generates the 2-bit select that the existing `mux_4_1` needs, and it adds valid/ready flow control on all four inputs and on the output. Throughput is one word per cycle and latency is one cycle.

---
 rtl/arb_mux_pkg.sv | 8 +
 rtl/mux_4_1.sv | 25 ++
 rtl/arb_mux_4_1.sv | 107 ++++++++++
 tb/tb_arb_mux_4_1.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and sizes for the round-robin arbiter / 4:1 mux slice.
package arb_mux_pkg;
  localparam int N_IN   = 4;
  localparam int DATA_W = 4;

  typedef logic [1:0]        src_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 data multiplexer; sel picks one of four words.
module mux_4_1
  import arb_mux_pkg::*;
(
  input  data_t d0,
  input  data_t d1,
  input  data_t d2,
  input  data_t d3,
  input  src_t  sel,
  output data_t y
);

  // Select the addressed word.
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/arb_mux_4_1.sv
// Round-robin arbiter over four valid/ready inputs, driving mux_4_1 and a
// single-entry registered output stage. Optional per-input saturating grant
// counters are built when ARB_MUX_STATS_EN is defined.
module arb_mux_4_1
  import arb_mux_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   in_valid,
  input  data_t             in_data0,
  input  data_t             in_data1,
  input  data_t             in_data2,
  input  data_t             in_data3,
  output logic [N_IN-1:0]   in_ready,
  output logic              out_valid,
  output data_t             out_data,
  output src_t              out_src,
  input  logic              out_ready
`ifdef ARB_MUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  grant_cnt2,
  output logic [CNT_W-1:0]  grant_cnt3
`endif
);

  src_t  ptr;
  src_t  winner;
  data_t mux_y;
  logic  ld;
  logic  any_valid;
  logic  xfer;

  assign ld        = !out_valid || out_ready;
  assign any_valid = |in_valid;

  // First valid input scanning upward from ptr; the descending loop lets the
  // lowest offset from ptr overwrite the others.
  always_comb begin
    winner = ptr;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (in_valid[ptr + src_t'(k)]) winner = ptr + src_t'(k);
    end
  end

  // One-hot accept for the winner; held off during reset and while the
  // output register is stalled.
  always_comb begin
    in_ready = '0;
    if (rst && ld && any_valid) in_ready[winner] = 1'b1;
  end

  assign xfer = |(in_valid & in_ready);

  mux_4_1 u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (winner),
    .y   (mux_y)
  );

  // Output register and round-robin pointer; ptr moves only on a transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (ld) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_y;
        out_src   <= winner;
        ptr       <= winner + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_STATS_EN
  logic [N_IN-1:0][CNT_W-1:0] cnt;

  // Saturating per-input grant counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid[i] && in_ready[i] && cnt[i] != {CNT_W{1'b1}})
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];
  assign grant_cnt2 = cnt[2];
  assign grant_cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Directed bench for arb_mux_4_1: reset, round-robin order, pointer wrap,
// back-pressure, reset flush and (when built with stats) counter saturation.
module tb_arb_mux_4_1;
  import arb_mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  data_t      in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  data_t      out_data;
  src_t       out_src;
  logic       out_ready;
`ifdef ARB_MUX_STATS_EN
  logic [1:0] grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;
`endif

  int errors = 0;
  int checks = 0;

  arb_mux_4_1 #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef ARB_MUX_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
    .grant_cnt2(grant_cnt2),
    .grant_cnt3(grant_cnt3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_d [5];

  initial begin
    exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC; exp_d[3] = 4'hD; exp_d[4] = 4'hA;
    rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
    in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
    tick();
    in_valid = 4'b1111; #1;
    chk("ready_in_reset", {4'b0, in_ready}, 8'h00);
    tick();
    in_valid = 4'b0000; rst = 1'b1; #1;
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_data", {4'b0, out_data}, 8'h00);
    chk("rst_src", {6'b0, out_src}, 8'h00);

    // Idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", {7'b0, out_valid}, 8'h00);
      chk("idle_ready", {4'b0, in_ready}, 8'h00);
      chk("idle_data", {4'b0, out_data}, 8'h00);
    end

    // All four requesting: 0,1,2,3,0 at one word per cycle.
    in_valid = 4'b1111; #1;
    chk("rr_ready0", {4'b0, in_ready}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_valid", {7'b0, out_valid}, 8'h01);
      chk("rr_src", {6'b0, out_src}, 8'(i % 4));
      chk("rr_data", {4'b0, out_data}, {4'b0, exp_d[i]});
    end
    // ptr is now 1; grant input 3 so ptr wraps to 0.
    in_valid = 4'b1000; #1;
    chk("g3_ready", {4'b0, in_ready}, 8'h08);
    tick();
    chk("g3_src", {6'b0, out_src}, 8'h03);
    in_valid = 4'b0100; in_data2 = 4'h5; #1;
    chk("wrap_ready", {4'b0, in_ready}, 8'h04);
    tick();
    chk("wrap_data", {4'b0, out_data}, 8'h05);
    chk("wrap_src", {6'b0, out_src}, 8'h02);
    chk("wrap_valid", {7'b0, out_valid}, 8'h01);

    // Back-pressure: output holds 5, ptr=3.
    out_ready = 1'b0; in_valid = 4'b0011; in_data0 = 4'h7; in_data1 = 4'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", {4'b0, in_ready}, 8'h00);
      tick();
      chk("stall_data", {4'b0, out_data}, 8'h05);
      chk("stall_valid", {7'b0, out_valid}, 8'h01);
    end
    out_ready = 1'b1; #1;
    chk("unstall_ready", {4'b0, in_ready}, 8'h01);
    tick();
    chk("unstall_data", {4'b0, out_data}, 8'h07);
    chk("unstall_src", {6'b0, out_src}, 8'h00);

    // Drain with nothing valid: valid drops, data/src hold.
    in_valid = 4'b0000;
    tick();
    chk("drain_valid", {7'b0, out_valid}, 8'h00);
    chk("drain_data", {4'b0, out_data}, 8'h07);
    chk("drain_src", {6'b0, out_src}, 8'h00);

    // Reset while holding a word.
    in_valid = 4'b0010;
    tick();
    chk("pre_rst_data", {4'b0, out_data}, 8'h08);
    chk("pre_rst_src", {6'b0, out_src}, 8'h01);
    out_ready = 1'b0; rst = 1'b0; in_valid = 4'b1111; #1;
    chk("rst_ready", {4'b0, in_ready}, 8'h00);
    tick();
    chk("flush_valid", {7'b0, out_valid}, 8'h00);
    chk("flush_data", {4'b0, out_data}, 8'h00);
    rst = 1'b1; out_ready = 1'b1; in_data0 = 4'hA; #1;
    chk("post_rst_ready", {4'b0, in_ready}, 8'h01);
    tick();
    chk("post_rst_src", {6'b0, out_src}, 8'h00);
    chk("post_rst_data", {4'b0, out_data}, 8'h0A);

`ifdef ARB_MUX_STATS_EN
    rst = 1'b0; in_valid = 4'b0000;
    tick();
    rst = 1'b1; in_valid = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cnt1", {6'b0, grant_cnt1}, (i < 3) ? 8'(i + 1) : 8'h03);
      chk("cnt_others", {2'b0, grant_cnt0, grant_cnt2, grant_cnt3}, 8'h00);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
